// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, WIDTH shift cycles per operation behind a start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] sa_r, sb_r, res_r, res_nx_s, d_r;
  logic [CW-1:0]    count_r;
  logic             borrow_r, bo_r, ovf_r, busy_r, done_r;
  logic             accept_s, last_s, x_s, y_s, diff_s, borrow_nx_s;

  // Full-subtractor cell: returns {borrow_out, diff}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic br);
    full_sub = {(~x & y) | (~(x ^ y) & br), x ^ y ^ br};
  endfunction

  // Bit-cell evaluation and handshake decode.
  always_comb begin
    x_s                    = sa_r[0];
    y_s                    = sb_r[0];
    {borrow_nx_s, diff_s}  = full_sub(x_s, y_s, borrow_r);
    last_s                 = (count_r == CW'(WIDTH - 1));
    accept_s               = start && ((state_r == IDLE) || (state_r == DONE));
  end

  // The result register shifts the new difference bit in at the MSB end.
  if (WIDTH == 1) begin : g_res_w1
    assign res_nx_s = diff_s;
  end else begin : g_res_wn
    assign res_nx_s = {diff_s, res_r[WIDTH-1:1]};
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = SHIFT;
        else       state_nx_s = IDLE;
      end
      SHIFT: begin
        if (last_s) state_nx_s = DONE;
        else        state_nx_s = SHIFT;
      end
      DONE: begin
        if (start) state_nx_s = SHIFT;
        else       state_nx_s = IDLE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register with registered busy/done flags decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == SHIFT);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // Datapath: operand capture on accept, one bit per cycle while shifting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_r     <= '0;
      sb_r     <= '0;
      res_r    <= '0;
      d_r      <= '0;
      count_r  <= '0;
      borrow_r <= 1'b0;
      bo_r     <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (accept_s) begin
      sa_r     <= a;
      sb_r     <= b;
      count_r  <= '0;
      borrow_r <= 1'b0;
      bo_r     <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (state_r == SHIFT) begin
      sa_r     <= sa_r >> 1;
      sb_r     <= sb_r >> 1;
      res_r    <= res_nx_s;
      borrow_r <= borrow_nx_s;
      count_r  <= count_r + CW'(1);
      // On the last step x/y are the operand sign bits.
      if (last_s) begin
        d_r   <= res_nx_s;
        bo_r  <= borrow_nx_s;
        ovf_r <= (x_s ^ y_s) & (diff_s ^ x_s);
      end else begin
        d_r   <= d_r;
        bo_r  <= bo_r;
        ovf_r <= ovf_r;
      end
    end else begin
      sa_r     <= sa_r;
      sb_r     <= sb_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign d    = d_r;
  assign bo   = bo_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8, 1 and 16: directed vectors plus
// back-to-back random operations checked against an arithmetic reference model.
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start8 = 1'b0, start1 = 1'b0, start16 = 1'b0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0, d8;
  logic [0:0]  a1 = 1'b0, b1 = 1'b0, d1;
  logic [15:0] a16 = 16'd0, b16 = 16'd0, d16;
  logic        busy8, done8, bo8, ovf8;
  logic        busy1, done1, bo1, ovf1;
  logic        busy16, done16, bo16, ovf16;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_done [3];
  bit   b2b_en [3];
  res_t q0[$], q1[$], q2[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .d(d8), .bo(bo8), .ovf(ovf8));
  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .d(d1), .bo(bo1), .ovf(ovf1));
  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .d(d16), .bo(bo16), .ovf(ovf16));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Arithmetic reference: modular difference, unsigned borrow, signed overflow.
  function automatic res_t model(input int w, input logic [15:0] av, input logic [15:0] bv);
    logic [16:0] m, s, x, y, df;
    res_t r;
    m  = (17'd1 << w) - 17'd1;
    s  = 17'd1 << (w - 1);
    x  = {1'b0, av} & m;
    y  = {1'b0, bv} & m;
    df = (x - y) & m;
    r.d   = df[15:0];
    r.bo  = (x < y);
    r.ovf = (((x ^ y) & s) != 17'd0) && (((df ^ x) & s) != 17'd0);
    return r;
  endfunction

  task automatic push(input int id, input res_t r);
    case (id)
      0:       q0.push_back(r);
      1:       q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask

  task automatic pop(input int id, output res_t r, output bit ok);
    ok = 1'b0;
    r  = '0;
    case (id)
      0:       if (q0.size() > 0) begin r = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin r = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin r = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic set_in(input int id, input logic [15:0] av, input logic [15:0] bv, input logic s);
    case (id)
      0:       begin a8  = av[7:0]; b8  = bv[7:0]; start8  = s; end
      1:       begin a1  = av[0:0]; b1  = bv[0:0]; start1  = s; end
      default: begin a16 = av;      b16 = bv;      start16 = s; end
    endcase
  endtask

  task automatic mon(input int id, input int w, input logic dn, input logic [15:0] dv,
                     input logic bov, input logic ov);
    res_t r;
    bit   ok;
    if (dn === 1'b1) begin
      pop(id, r, ok);
      chk($sformatf("w%0d_done_expected", w), {31'd0, ok}, 32'd1);
      if (ok) begin
        chk($sformatf("w%0d_d", w),   {16'd0, dv}, {16'd0, r.d});
        chk($sformatf("w%0d_bo", w),  {31'd0, bov}, {31'd0, r.bo});
        chk($sformatf("w%0d_ovf", w), {31'd0, ov},  {31'd0, r.ovf});
      end
      if (b2b_en[id]) begin
        if (last_done[id] != 0) chk($sformatf("w%0d_done_period", w), cyc - last_done[id], w + 1);
        last_done[id] = cyc;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 8,  done8,  {8'd0, d8},  bo8,  ovf8);
    mon(1, 1,  done1,  {15'd0, d1}, bo1,  ovf1);
    mon(2, 16, done16, d16,         bo16, ovf16);
  end

  // Single operation from idle on the WIDTH=8 unit; also measures start-to-done latency.
  task automatic run_op(input string nm, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic ebo, input logic eovf);
    res_t r;
    int   lat = 0;
    @(posedge clk); #1;
    a8 = av; b8 = bv; start8 = 1'b1;
    r.d = {8'd0, ed}; r.bo = ebo; r.ovf = eovf;
    push(0, r);
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done8 === 1'b1 && lat == 0) lat = k;
    end
    chk({nm, "_latency"}, lat, 9);
  endtask

  // Start held high: each op is accepted on the DONE cycle of the previous one.
  task automatic rand_b2b(input int id, input int w, input int n);
    logic [15:0] av, bv;
    b2b_en[id] = 1'b1;
    last_done[id] = 0;
    @(posedge clk); #1;
    av = 16'($urandom); bv = 16'($urandom);
    set_in(id, av, bv, 1'b1);
    push(id, model(w, av, bv));
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      av = 16'($urandom); bv = 16'($urandom);
      set_in(id, av, bv, 1'b1);
      push(id, model(w, av, bv));
      repeat (w) @(posedge clk);
    end
    @(posedge clk); #1;
    set_in(id, 16'd0, 16'd0, 1'b0);
    repeat (w + 3) @(posedge clk);
    b2b_en[id] = 1'b0;
    case (id)
      0:       chk("w8_queue_drained", q0.size(), 0);
      1:       chk("w1_queue_drained", q1.size(), 0);
      default: chk("w16_queue_drained", q2.size(), 0);
    endcase
  endtask

  initial begin
    int busy_cnt, done_cnt;
    res_t r;
    for (int i = 0; i < 3; i++) begin b2b_en[i] = 1'b0; last_done[i] = 0; end
    #23;
    chk("reset_w8",  {19'd0, busy8, done8, bo8, ovf8, d8}, 32'd0);
    chk("reset_w16", {12'd0, busy16, done16, bo16, ovf16, d16}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {30'd0, busy8, done8}, 32'd0);

    run_op("t1_100m58", 8'd100,  8'd58,   8'd42,   1'b0, 1'b0);
    run_op("t2_5m7",    8'd5,    8'd7,    8'hFE,   1'b1, 1'b0);
    run_op("t2_0m0",    8'd0,    8'd0,    8'd0,    1'b0, 1'b0);
    run_op("t3_80m01",  8'h80,   8'h01,   8'h7F,   1'b0, 1'b1);
    run_op("t3_7Fm FF", 8'h7F,   8'hFF,   8'h80,   1'b1, 1'b1);

    // Ignored start and operand changes while shifting.
    @(posedge clk); #1;
    a8 = 8'd9; b8 = 8'd3; start8 = 1'b1;
    r.d = 16'd6; r.bo = 1'b0; r.ovf = 1'b0;
    push(0, r);
    @(posedge clk); #1;
    start8 = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (busy8 === 1'b1) busy_cnt++;
      if (done8 === 1'b1) done_cnt++;
      if (k == 2) begin a8 = 8'd1; b8 = 8'd1; start8 = 1'b1; end
      if (k == 3) begin a8 = 8'hAA; b8 = 8'h55; start8 = 1'b0; end
    end
    chk("t4_busy_cycles", busy_cnt, 8);
    chk("t4_done_count", done_cnt, 1);

    // Asynchronous reset in the 4th shift cycle discards the operation.
    @(posedge clk); #1;
    a8 = 8'd50; b8 = 8'd10; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("t5_async_reset", {19'd0, busy8, done8, bo8, ovf8, d8}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) done_cnt++;
    end
    chk("t5_no_done_after_abort", done_cnt, 0);
    run_op("t5_20m21", 8'd20, 8'd21, 8'hFF, 1'b1, 1'b0);

    fork
      rand_b2b(0, 8, 1000);
      rand_b2b(1, 1, 1000);
      rand_b2b(2, 16, 1000);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
